// File: rtl/l1i_pkg.sv
// rtl/l1i_pkg.sv - shared constants, FSM state type and address helpers for the L1 I-cache controller
package l1i_pkg;

  localparam int ADDR_W_DFLT = 32;
  localparam int INDEX_W     = 2;
  localparam int OFFSET_W    = 6;
  localparam int TAG_W       = ADDR_W_DFLT - INDEX_W - OFFSET_W;
  localparam int NUM_SETS    = 1 << INDEX_W;
  localparam int NUM_WAYS    = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS
  } state_e;

  typedef struct packed {
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } line_pos_t;

  // Splits the low address bits into set index and byte offset within the line.
  function automatic line_pos_t line_pos(input logic [INDEX_W+OFFSET_W-1:0] low);
    return line_pos_t'(low);
  endfunction

endpackage

// File: rtl/l1i_tag_array.sv
// rtl/l1i_tag_array.sv - tag/valid/LRU storage with hit detection, victim choice, fill and flush
module l1i_tag_array
  import l1i_pkg::*;
#(
  parameter int TAG_BITS = TAG_W
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [INDEX_W-1:0]  index,
  input  logic [TAG_BITS-1:0] tag,
  output logic                hit,
  output logic                hit_way,
  output logic                victim_way,
  input  logic                touch,
  input  logic                fill,
  input  logic                fill_way,
  input  logic                flush
);

  logic [TAG_BITS-1:0] tags  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid [NUM_SETS];
  logic [NUM_SETS-1:0] lru;
  logic [NUM_WAYS-1:0] match;

  always_comb begin
    match = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match[w] = valid[index][w] && (tags[index][w] == tag);
    end
  end

  // A double match cannot arise legally; way 0 wins if it ever does.
  assign hit        = |match;
  assign hit_way    = ~match[0];
  assign victim_way = !valid[index][0] ? 1'b0 :
                      !valid[index][1] ? 1'b1 : lru[index];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          tags[s][w] <= '0;
        end
      end
      lru <= '0;
    end else begin
      if (flush) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          valid[s] <= '0;
        end
      end
      if (fill) begin
        tags[index][fill_way]  <= tag;
        valid[index][fill_way] <= 1'b1;
      end
      if (touch) begin
        lru[index] <= ~hit_way;
      end
    end
  end

endmodule

// File: rtl/l1_i_cache_ctrl.sv
// rtl/l1_i_cache_ctrl.sv - L1 I-cache control FSM: lookup, victim refill from L2, data array steering
// Optional hit/miss counters are enabled with L1I_PERF_CNT_EN.
module l1_i_cache_ctrl
  import l1i_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                cpu_req,
  input  logic [ADDR_W-1:0]   cpu_addr,
  output logic                cpu_ready,
  output logic                cpu_valid,
  input  logic                flush,
  output logic                l2_req,
  output logic [ADDR_W-1:0]   l2_addr,
  input  logic                l2_ready,
  output logic [INDEX_W-1:0]  index_C_L1,
  output logic [OFFSET_W-1:0] offset,
  output logic                way,
  output logic                refill
`ifdef L1I_PERF_CNT_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`endif
);

  localparam int LTAG_W = ADDR_W - INDEX_W - OFFSET_W;

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  line_pos_t         pos;
  logic              hit;
  logic              hit_way;
  logic              victim_way;

  assign pos        = line_pos(addr_q[INDEX_W+OFFSET_W-1:0]);
  assign index_C_L1 = pos.index;
  assign offset     = pos.offset;
  assign l2_addr    = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};

  // A flush takes the idle cycle, so a request presented alongside it must be held.
  assign cpu_ready  = (state == IDLE) && !flush;
  // The refill strobe must coincide with the cycle the line sits on the L2 data bus.
  assign refill     = (state == MISS) && l2_ready;

  l1i_tag_array #(
    .TAG_BITS (LTAG_W)
  ) u_tag_array (
    .clk        (clk),
    .nrst       (nrst),
    .index      (pos.index),
    .tag        (addr_q[ADDR_W-1 -: LTAG_W]),
    .hit        (hit),
    .hit_way    (hit_way),
    .victim_way (victim_way),
    .touch      ((state == LOOKUP) && hit),
    .fill       (refill),
    .fill_way   (way),
    .flush      ((state == IDLE) && flush)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      addr_q    <= '0;
      cpu_valid <= 1'b0;
      l2_req    <= 1'b0;
      way       <= 1'b0;
    end else begin
      cpu_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush && cpu_req) begin
            addr_q <= cpu_addr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            way       <= hit_way;
            cpu_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            way    <= victim_way;
            l2_req <= 1'b1;
            state  <= MISS;
          end
        end
        MISS: begin
          if (l2_ready) begin
            l2_req <= 1'b0;
            state  <= LOOKUP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef L1I_PERF_CNT_EN
  logic relookup;

  // The lookup that follows a refill always hits and is not a genuine hit.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      relookup <= 1'b0;
    end else begin
      if (refill) begin
        relookup <= 1'b1;
      end else if (state == LOOKUP) begin
        relookup <= 1'b0;
      end
      if (state == LOOKUP) begin
        if (hit && !relookup) begin
          hit_cnt <= hit_cnt + 32'd1;
        end
        if (!hit) begin
          miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_l1_i_cache_ctrl.sv
// tb/tb_l1_i_cache_ctrl.sv - self-checking bench for l1_i_cache_ctrl against a cache-state model
module tb_l1_i_cache_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        cpu_req = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic        flush = 1'b0;
  logic        l2_ready = 1'b0;
  logic        cpu_ready, cpu_valid, l2_req, way, refill;
  logic [31:0] l2_addr;
  logic [1:0]  index_C_L1;
  logic [5:0]  offset;

  int errors = 0;
  int checks = 0;

  logic [23:0] mt   [4][2];
  bit          mv   [4][2];
  bit          mlru [4];

  l1_i_cache_ctrl dut (
    .clk        (clk),
    .nrst       (nrst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ready  (cpu_ready),
    .cpu_valid  (cpu_valid),
    .flush      (flush),
    .l2_req     (l2_req),
    .l2_addr    (l2_addr),
    .l2_ready   (l2_ready),
    .index_C_L1 (index_C_L1),
    .offset     (offset),
    .way        (way),
    .refill     (refill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      mlru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 0;
        mt[s][w] = '0;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, cpu_ready, 1);
    chk({tag, "_valid"}, cpu_valid, 0);
    chk({tag, "_l2req"}, l2_req, 0);
    chk({tag, "_refill"}, refill, 0);
    chk({tag, "_way"}, way, 0);
    chk({tag, "_index"}, index_C_L1, 0);
    chk({tag, "_offset"}, offset, 0);
    chk({tag, "_l2addr"}, l2_addr, 0);
  endtask

  // One fetch, optionally preceded by a flush in the same idle cycle; l2_cycles = cycles l2_req stays high.
  task automatic fetch(input logic [31:0] a, input int l2_cycles, input bit with_flush,
                       output int lat, output bit saw_l2, output bit vway);
    logic [1:0]  set;
    logic [23:0] tag;
    bit          h0, h1, exp_hit, exp_way, done;
    int          l2cnt, refills;
    set = a[7:6];
    tag = a[31:8];
    @(negedge clk);
    chk("idle_valid_low", cpu_valid, 0);
    if (with_flush) begin
      cpu_req = 1; cpu_addr = a; flush = 1;
      #1;
      chk("flush_ready_low", cpu_ready, 0);
      @(negedge clk);
      flush = 0;
      for (int s = 0; s < 4; s++) begin
        mv[s][0] = 0; mv[s][1] = 0;
      end
    end
    h0 = mv[set][0] && mt[set][0] == tag;
    h1 = mv[set][1] && mt[set][1] == tag;
    exp_hit = h0 || h1;
    if (h0) exp_way = 0;
    else if (h1) exp_way = 1;
    else if (!mv[set][0]) exp_way = 0;
    else if (!mv[set][1]) exp_way = 1;
    else exp_way = mlru[set];
    cpu_req = 1; cpu_addr = a;
    #1;
    chk("accept_ready", cpu_ready, 1);
    lat = 0; saw_l2 = 0; vway = 0; l2cnt = 0; refills = 0; done = 0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      cpu_req = 0;
      cpu_addr = $urandom;
      if (l2_req) begin
        l2cnt++;
        saw_l2 = 1;
        chk("l2_way", way, exp_way);
        chk("l2_addr", l2_addr, {a[31:6], 6'b0});
        l2_ready = (l2cnt >= l2_cycles);
        flush = 1'($urandom_range(0, 1));
      end else begin
        l2_ready = 1'($urandom_range(0, 1));
        flush = 0;
      end
      #1;
      chk("refill", refill, l2_req && l2_ready);
      if (refill) refills++;
      if (cpu_valid) begin
        done = 1;
        lat = k;
        vway = way;
        chk("valid_way", way, exp_way);
        chk("valid_index", index_C_L1, set);
        chk("valid_offset", offset, a[5:0]);
        chk("valid_ready", cpu_ready, 1);
      end else begin
        chk("busy_ready", cpu_ready, 0);
      end
    end
    l2_ready = 0;
    flush = 0;
    chk("fetch_done", done, 1);
    chk("latency", lat, exp_hit ? 2 : l2_cycles + 3);
    chk("l2_cycles", l2cnt, exp_hit ? 0 : l2_cycles);
    chk("refill_count", refills, exp_hit ? 0 : 1);
    if (!exp_hit) begin
      mt[set][exp_way] = tag;
      mv[set][exp_way] = 1;
    end
    mlru[set] = ~exp_way;
  endtask

  task automatic reset_mid_miss(input logic [31:0] a);
    @(negedge clk);
    cpu_req = 1; cpu_addr = a;
    @(negedge clk);
    cpu_req = 0;
    @(negedge clk);
    chk("rst_pre_l2req", l2_req, 1);
    nrst = 0;
    #1;
    chk_reset_outputs("rst_mid");
    l2_ready = 1;
    #1;
    chk("rst_mid_refill", refill, 0);
    @(negedge clk);
    nrst = 1;
    #1;
    chk("rst_post_refill", refill, 0);
    @(negedge clk);
    chk("rst_post_refill2", refill, 0);
    chk("rst_post_ready", cpu_ready, 1);
    chk("rst_post_l2req", l2_req, 0);
    l2_ready = 0;
    model_reset();
  endtask

  initial begin
    int lat;
    bit s, w;
    logic [31:0] a;
    model_reset();
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    nrst = 1;

    // Cold miss, L2 answers on the first l2_req cycle.
    fetch(32'h0000_1044, 1, 0, lat, s, w);
    chk("t1_lat", lat, 4); chk("t1_l2", s, 1); chk("t1_way", w, 0);
    chk("t1_l2addr", l2_addr, 32'h0000_1040); chk("t1_index", index_C_L1, 1);

    fetch(32'h0000_1048, 1, 0, lat, s, w);
    chk("t2_lat", lat, 2); chk("t2_l2", s, 0); chk("t2_way", w, 0);

    fetch(32'h0000_2040, 2, 0, lat, s, w);
    chk("t3a_l2", s, 1); chk("t3a_way", w, 1);
    fetch(32'h0000_1040, 1, 0, lat, s, w);
    chk("t3b_l2", s, 0); chk("t3b_way", w, 0);
    fetch(32'h0000_3040, 1, 0, lat, s, w);
    chk("t3c_l2", s, 1); chk("t3c_way", w, 1);
    fetch(32'h0000_2040, 1, 0, lat, s, w);
    chk("t3d_l2", s, 1); chk("t3d_way", w, 0);

    fetch(32'h0000_4044, 5, 0, lat, s, w);
    chk("t4_lat", lat, 8); chk("t4_way", w, 1);

    fetch(32'h0000_1000, 1, 0, lat, s, w);
    fetch(32'h0000_2000, 1, 0, lat, s, w);
    fetch(32'h0000_1000, 1, 0, lat, s, w);
    chk("t5_prehit", s, 0);
    fetch(32'h0000_1000, 1, 1, lat, s, w);
    chk("t5_l2", s, 1); chk("t5_way", w, 0); chk("t5_lat", lat, 4);

    reset_mid_miss(32'hABCD_E0C0);
    fetch(32'h0000_1044, 1, 0, lat, s, w);
    chk("t6_l2", s, 1); chk("t6_lat", lat, 4);

    for (int i = 0; i < 200; i++) begin
      a = {22'($urandom_range(0, 3)) << 2, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 6'($urandom)};
      fetch(a, $urandom_range(1, 4), ($urandom_range(0, 9) == 0), lat, s, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
